// File: rtl/binary_adder_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder controller.
package binary_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Slice counter width; never below one bit even for a single slice.
  function automatic int idx_width(input int width, input int chunk);
    int n;
    n = nchunk(width, chunk);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/binary_adder_seq_ctrl_if.sv
// ap_ctrl_hs-style request/result bundle between a requester and the adder controller.
interface binary_adder_seq_ctrl_if #(
  parameter int WIDTH = 100
);
  logic             ap_start;
  logic             ap_ready;
  logic             ap_idle;
  logic             ap_done;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output ap_start, a, b, cin,
    input  ap_ready, ap_idle, ap_done, sum, cout
  );

  modport slave (
    input  ap_start, a, b, cin,
    output ap_ready, ap_idle, ap_done, sum, cout
  );
endinterface

// File: rtl/binary_adder_seq_ctrl_adder_chunk.sv
// One CHUNK-bit combinational adder slice with carry in and carry out.
module adder_chunk #(
  parameter int CHUNK = 25
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

// File: rtl/binary_adder_seq_ctrl.sv
// Sequencing controller: adds two WIDTH-bit operands one CHUNK-bit slice per cycle
// through a single adder slice, then presents a held sum/cout with an ap_done pulse.
module binary_adder_seq_ctrl
  import binary_adder_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int CHUNK = 25
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  binary_adder_seq_ctrl_if.slave bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(WIDTH, CHUNK);
  localparam int PADW   = NCHUNK * CHUNK;
  localparam int LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [PADW-1:0]  work_q, work_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             accept;
  logic [PADW-1:0]  a_pad, b_pad, work_nx;
  logic [CHUNK-1:0] a_sl [NCHUNK];
  logic [CHUNK-1:0] b_sl [NCHUNK];
  logic [CHUNK-1:0] slice_a, slice_b, slice_s;
  logic             slice_co, last_co;

  // Held in reset, no request may be accepted even though the state decodes as IDLE.
  assign accept = ap_rst_n && bus.ap_start && ((state_q == IDLE) || (state_q == DONE));

  // Zero padding above WIDTH masks the part of the last slice beyond the operands.
  assign a_pad = PADW'(op_a_q);
  assign b_pad = PADW'(op_b_q);

  genvar gi;
  for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign a_sl[gi] = a_pad[gi*CHUNK +: CHUNK];
    assign b_sl[gi] = b_pad[gi*CHUNK +: CHUNK];
    assign work_nx[gi*CHUNK +: CHUNK] =
        (idx_q == IDXW'(gi)) ? slice_s : work_q[gi*CHUNK +: CHUNK];
  end

  assign slice_a = a_sl[idx_q];
  assign slice_b = b_sl[idx_q];

  adder_chunk #(.CHUNK(CHUNK)) u_adder_chunk (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // A narrow last slice carries out of bit LASTW-1 into the first padding bit.
  if (LASTW == CHUNK) begin : g_full_last
    assign last_co = slice_co;
  end else begin : g_short_last
    assign last_co = slice_s[LASTW];
  end

  // State register
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? RUN : IDLE;
      RUN:     state_d = (idx_q == LAST_IDX) ? DONE : RUN;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    bus.ap_ready = accept;
    bus.ap_idle  = (state_q == IDLE);
    bus.ap_done  = (state_q == DONE);
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      op_a_d  = bus.a;
      op_b_d  = bus.b;
      carry_d = bus.cin;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      work_d  = work_nx;
      carry_d = slice_co;
      idx_d   = idx_q + IDXW'(1);
      if (idx_q == LAST_IDX) begin
        sum_d  = work_nx[WIDTH-1:0];
        cout_d = last_co;
        idx_d  = '0;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      idx_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: doc/binary_adder_seq_ctrl.md
# binary_adder_seq_ctrl

- Sequencing controller for the 100-bit binary adder.
- Accepts two WIDTH-bit operands and a carry-in under an ap_ctrl_hs-style handshake.
- Computes the sum over ceil(WIDTH/CHUNK) cycles using one CHUNK-bit adder slice and a registered carry.
- Presents a held result with a one-cycle ap_done pulse; trades latency for a narrow carry chain in the HLS adder top level.

## Interface
Parameters:
- WIDTH, 100, operand/result width in bits
- CHUNK, 25, slice width per cycle; legal range 1..WIDTH; need not divide WIDTH

Ports:
- ap_clk  in  1  clock; all state changes on rising edge
- ap_rst_n  in  1  reset, synchronous and active-low
- ap_start  in  1  request; sampled only in IDLE or DONE
- ap_ready  out  1  high in the cycle a request is accepted (operands consumed)
- ap_idle  out  1  high while in IDLE
- ap_done  out  1  one-cycle pulse; sum/cout valid from this cycle
- a  in  WIDTH  operand A, sampled on acceptance only
- b  in  WIDTH  operand B, sampled on acceptance only
- cin  in  1  carry-in, sampled on acceptance only
- sum  out  WIDTH  registered result, held until the next ap_done
- cout  out  1  registered carry-out, held with sum

## Operation
- NCHUNK = ceil(WIDTH/CHUNK).
- Last slice width = WIDTH - (NCHUNK-1)*CHUNK.
- cout is the carry out of the last slice's MSB; no bits beyond WIDTH.

States:
- IDLE
  - ap_start=1: latch a, b, cin into op registers; idx=0; ap_ready=1 (combinational); go RUN.
  - otherwise: stay.
- RUN
  - Add slice idx of A and B plus the carry register.
  - Write the slice into the work register; update the carry register; idx++.
  - At idx==NCHUNK-1: copy the completed work register into sum and the final carry into cout (same edge); go DONE.
- DONE
  - ap_done=1.
  - ap_start=1: accept a new request exactly as in IDLE (ap_ready=1, latch); go RUN.
  - otherwise: go IDLE.

Rules:
- ap_start while in RUN is ignored; it is not queued.
- a, b, cin changes after acceptance have no effect.
- sum/cout change only on the edge entering DONE. Partial results are never visible.
- Slices wider than the remainder are masked. Upper operand bits beyond WIDTH do not exist; no X propagation.
- CHUNK=WIDTH: a single RUN cycle.

## Timing
- Reset values (ap_rst_n=0 at an edge): state IDLE, ap_idle=1, ap_ready=0, ap_done=0, sum=0, cout=0, idx=0, carry=0.
- ap_ready is combinational from ap_start and state. ap_idle and ap_done are decoded from registered state.
- Acceptance in cycle T:
  - RUN occupies T+1..T+NCHUNK.
  - ap_done in cycle T+NCHUNK+1.
  - Default configuration: ap_done at T+5.
- Initiation interval:
  - NCHUNK+1 with ap_start held high (accept in the DONE cycle).
  - NCHUNK+2 with an intervening IDLE cycle.
- Reset asserted mid-RUN or in DONE: the operation is abandoned and outputs return to reset values on that edge. No ap_done is issued for the abandoned request.
- Simultaneous ap_done and acceptance in DONE: both pulses occur in the same cycle. sum holds the finished result until the next operation's DONE entry.

## Structure
- Package binary_adder_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - function nchunk(WIDTH, CHUNK)
  - idx width $clog2(max(NCHUNK,2))
- Sub-module adder_chunk holds the CHUNK-bit combinational slice add: a, b, ci -> s, co.
- The controller owns the FSM, idx counter, op/work/carry registers and output registers.

## Test plan
- Reset: hold ap_rst_n=0 two cycles with ap_start=1 -> ap_idle=1, ap_ready=0, ap_done=0, sum=0, cout=0 throughout; no acceptance.
- Full carry ripple: a=2^100-1, b=1, cin=0, ap_start at T -> ap_ready at T; ap_done only at T+5; sum=0, cout=1.
- Chunk boundary: a=2^25-1, b=0, cin=1 -> sum=2^25, cout=0. Inputs changed at T+1 do not alter the result. sum stays at its prior value during RUN.
- Back-to-back: ap_start held high for two requests (3+4, then 10+20) -> ap_ready at T and T+5; ap_done at T+5 (sum=7) and T+10 (sum=30); sum=7 held T+5..T+9.
- Mid-run reset: accept at T, ap_rst_n=0 at T+2 -> outputs at reset values from T+3; no ap_done ever; ap_idle=1.
- CHUNK=30 (last slice 10 bits): 1000 random a, b, cin -> {cout,sum} == a+b+cin; ap_done exactly 5 cycles after each acceptance.
